// File: rtl/led_out_sequencer_if.sv
// led_out_sequencer_if: request/boundary inputs and mux-control outputs of the LED output sequencer
interface led_out_sequencer_if #(parameter int NUM_ID_FRAMES = 16);
  localparam int IW = $clog2(NUM_ID_FRAMES);
  logic calib_start_in;
  logic calib_abort_in;
  logic moving_req_in;
  logic frame_done_in;
  logic led_out_mux_mode;
  logic moving_override_out;
  logic [IW-1:0] id_frame_idx_out;
  logic capture_strobe_out;
  logic calib_busy_out;
  logic calib_done_out;
  modport master (
    output calib_start_in, calib_abort_in, moving_req_in, frame_done_in,
    input led_out_mux_mode, moving_override_out, id_frame_idx_out,
    input capture_strobe_out, calib_busy_out, calib_done_out
  );
  modport slave (
    input calib_start_in, calib_abort_in, moving_req_in, frame_done_in,
    output led_out_mux_mode, moving_override_out, id_frame_idx_out,
    output capture_strobe_out, calib_busy_out, calib_done_out
  );
endinterface

// File: rtl/led_out_sequencer.sv
// led_out_sequencer: frame-synchronous mux mode, ID-calibration and moving-override sequencer
module led_out_sequencer #(
  parameter int NUM_ID_FRAMES = 16,
  parameter int FRAMES_PER_ID = 4,
  parameter int SETTLE_FRAMES = 2,
  parameter int MOVING_FRAMES = 60
) (
  input logic clk_in,
  input logic rst_in,
  led_out_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_ID_FRAMES);
  localparam int HW = $clog2(FRAMES_PER_ID + 1);
  localparam int MW = $clog2(MOVING_FRAMES + 1);
  typedef enum logic [1:0] {CAMERA, CALIB, MOVING} state_t;
  state_t state_q, state_d;
  logic calib_pend_q, calib_pend_d, mov_pend_q, mov_pend_d, abort_pend_q, abort_pend_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [MW-1:0] mov_cnt_q, mov_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic mode_q, mode_d, ovr_q, ovr_d, strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;
  logic cp, fd;
  always_comb begin
    state_d = state_q;
    calib_pend_d = calib_pend_q;
    mov_pend_d = mov_pend_q;
    abort_pend_d = abort_pend_q;
    hold_d = hold_q;
    mov_cnt_d = mov_cnt_q;
    idx_d = idx_q;
    strobe_d = 1'b0;
    done_d = 1'b0;
    fd = bus.frame_done_in;
    cp = calib_pend_q | bus.calib_start_in;
    case (state_q)
      CAMERA: begin
        calib_pend_d = cp;
        mov_pend_d = mov_pend_q | bus.moving_req_in;
        if (fd && cp) begin
          state_d = CALIB;
          idx_d = '0;
          hold_d = '0;
          calib_pend_d = 1'b0;
          mov_pend_d = 1'b0;
        end else if (fd && mov_pend_d) begin
          state_d = MOVING;
          mov_cnt_d = '0;
          mov_pend_d = 1'b0;
        end
      end
      CALIB: begin
        abort_pend_d = abort_pend_q | bus.calib_abort_in;
        if (fd && abort_pend_d) begin
          state_d = CAMERA;
          idx_d = '0;
          hold_d = '0;
          abort_pend_d = 1'b0;
        end else if (fd) begin
          strobe_d = hold_q == HW'(SETTLE_FRAMES - 1);
          hold_d = (hold_q == HW'(FRAMES_PER_ID - 1)) ? '0 : hold_q + 1'b1;
          if (hold_q == HW'(FRAMES_PER_ID - 1)) begin
            done_d = idx_q == IW'(NUM_ID_FRAMES - 1);
            idx_d = done_d ? '0 : idx_q + 1'b1;
            state_d = done_d ? CAMERA : CALIB;
          end
        end
      end
      MOVING: begin
        calib_pend_d = cp;
        if (fd && cp) begin
          state_d = CALIB;
          idx_d = '0;
          hold_d = '0;
          calib_pend_d = 1'b0;
        end else if (bus.moving_req_in) begin
          mov_cnt_d = '0;
        end else if (fd) begin
          state_d = (mov_cnt_q == MW'(MOVING_FRAMES - 1)) ? CAMERA : MOVING;
          mov_cnt_d = mov_cnt_q + 1'b1;
        end
      end
      default: state_d = CAMERA;
    endcase
    mode_d = state_d != CALIB;
    ovr_d = state_d == MOVING;
    busy_d = (state_d == CALIB) | calib_pend_d;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= CAMERA;
      calib_pend_q <= 1'b0;
      mov_pend_q <= 1'b0;
      abort_pend_q <= 1'b0;
      hold_q <= '0;
      mov_cnt_q <= '0;
      idx_q <= '0;
      mode_q <= 1'b1;
      ovr_q <= 1'b0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      calib_pend_q <= calib_pend_d;
      mov_pend_q <= mov_pend_d;
      abort_pend_q <= abort_pend_d;
      hold_q <= hold_d;
      mov_cnt_q <= mov_cnt_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      ovr_q <= ovr_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.led_out_mux_mode = mode_q;
  assign bus.moving_override_out = ovr_q;
  assign bus.id_frame_idx_out = idx_q;
  assign bus.capture_strobe_out = strobe_q;
  assign bus.calib_busy_out = busy_q;
  assign bus.calib_done_out = done_q;
endmodule

// File: tb/tb_led_out_sequencer.sv
// tb_led_out_sequencer: randomized scoreboard bench against a frame-counting reference model
module tb_led_out_sequencer;
  localparam int N = 16, F = 4, S = 2, M = 60;
  localparam int IW = $clog2(N);
  typedef struct packed {
    logic mode;
    logic ovr;
    logic [IW-1:0] idx;
    logic strb;
    logic busy;
    logic done;
  } obs_t;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  led_out_sequencer_if #(.NUM_ID_FRAMES(N)) bus ();
  led_out_sequencer #(.NUM_ID_FRAMES(N), .FRAMES_PER_ID(F), .SETTLE_FRAMES(S), .MOVING_FRAMES(M)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .bus(bus)
  );
  always #5 clk = ~clk;
  obs_t exp_q[$];
  int checks = 0, errors = 0;
  bit in_calib, in_moving, calib_req, mov_req, abort_req;
  int calib_frames, mov_left;
  task automatic model(input bit st, input bit ab, input bit mr, input bit fd, input bit rs);
    obs_t e;
    bit cr;
    e.strb = 1'b0;
    e.done = 1'b0;
    if (rs) begin
      in_calib = 0; in_moving = 0; calib_req = 0; mov_req = 0; abort_req = 0;
      calib_frames = 0; mov_left = 0;
    end else if (in_calib) begin
      abort_req |= ab;
      if (fd && abort_req) begin
        in_calib = 0; abort_req = 0; calib_frames = 0;
      end else if (fd) begin
        e.strb = (calib_frames % F) == S - 1;
        calib_frames++;
        if (calib_frames == N * F) begin
          in_calib = 0; calib_frames = 0; e.done = 1'b1;
        end
      end
    end else begin
      cr = calib_req | st;
      if (fd && cr) begin
        in_calib = 1; in_moving = 0; calib_frames = 0; calib_req = 0; mov_req = 0;
      end else if (in_moving) begin
        calib_req = cr;
        if (mr) mov_left = M;
        else if (fd && --mov_left == 0) in_moving = 0;
      end else begin
        calib_req = cr;
        mov_req |= mr;
        if (fd && mov_req) begin
          in_moving = 1; mov_left = M; mov_req = 0;
        end
      end
    end
    e.mode = !in_calib;
    e.ovr = in_moving;
    e.idx = IW'(in_calib ? calib_frames / F : 0);
    e.busy = in_calib | calib_req;
    exp_q.push_back(e);
  endtask
  task automatic cycle(input bit st, input bit ab, input bit mr, input bit fd, input bit rs);
    bus.calib_start_in = st;
    bus.calib_abort_in = ab;
    bus.moving_req_in = mr;
    bus.frame_done_in = fd;
    rst_in = rs;
    @(posedge clk);
    #1;
    model(st, ab, mr, fd, rs);
    bus.calib_start_in = 0;
    bus.calib_abort_in = 0;
    bus.moving_req_in = 0;
    bus.frame_done_in = 0;
    rst_in = 0;
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
    end
  endtask
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{bus.led_out_mux_mode, bus.moving_override_out, bus.id_frame_idx_out,
            bus.capture_strobe_out, bus.calib_busy_out, bus.calib_done_out};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {mode,ovr,idx,strb,busy,done}: got %b %b %0d %b %b %b expected %b %b %0d %b %b %b",
                 $time, a.mode, a.ovr, a.idx, a.strb, a.busy, a.done, e.mode, e.ovr, e.idx, e.strb, e.busy, e.done);
      end
    end
  end
  initial begin
    #5000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    bus.calib_start_in = 0;
    bus.calib_abort_in = 0;
    bus.moving_req_in = 0;
    bus.frame_done_in = 0;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({bus.led_out_mux_mode, bus.moving_override_out, bus.id_frame_idx_out, bus.capture_strobe_out,
         bus.calib_busy_out, bus.calib_done_out} !== {1'b1, 1'b0, IW'(0), 3'b000}) begin
      errors++;
      $display("FAIL reset state: mode=%b ovr=%b idx=%0d strb=%b busy=%b done=%b", bus.led_out_mux_mode,
               bus.moving_override_out, bus.id_frame_idx_out, bus.capture_strobe_out, bus.calib_busy_out,
               bus.calib_done_out);
    end
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    frames(N * F + 2);
    cycle(0, 0, 1, 0, 0);
    frames(30);
    cycle(0, 0, 1, 0, 0);
    frames(M + 2);
    cycle(0, 0, 1, 0, 0);
    frames(3);
    cycle(1, 0, 0, 0, 0);
    frames(N * F + 2);
    cycle(1, 0, 0, 0, 0);
    frames(1 + 5 * F + 1);
    cycle(0, 1, 0, 0, 0);
    frames(3);
    cycle(1, 0, 1, 1, 0);
    frames(5);
    cycle(0, 1, 0, 0, 0);
    frames(M + 3);
    cycle(1, 0, 0, 0, 0);
    frames(1 + 7 * F + 2);
    cycle(0, 0, 0, 0, 1);
    frames(2);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 40, $urandom_range(0, 999) < 2);
    @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_out_sequencer.md
# led_out_sequencer

Frame-synchronous controller for the LED output multiplexer. It drives the mux mode select and the moving-pixel override so that the strand shows the camera colour stream by default. On request it steps the ID shower through a fixed sequence of calibration ID frames and strobes the camera capture at a settled point within each ID. It also grants timed moving-pixel override windows. Every change of the mux selection takes effect only at a frame boundary (`frame_done_in`), so a frame is never torn between sources.

## Interface
Parameters:
- `NUM_ID_FRAMES`, 16: ID patterns per calibration run; must be ≥ 2.
- `FRAMES_PER_ID`, 4: LED frames each ID pattern is held.
- `SETTLE_FRAMES`, 2: frames shown before capture; 1 ≤ `SETTLE_FRAMES` ≤ `FRAMES_PER_ID`.
- `MOVING_FRAMES`, 60: length of an override window, in frames; must be ≥ 1.

Ports:
- `clk_in`  in  1: system clock. The block has one clock.
- `rst_in`  in  1: reset. It is synchronous and active-high.
- `calib_start_in`  in  1: single-cycle request to run a calibration.
- `calib_abort_in`  in  1: single-cycle request to abort a calibration.
- `moving_req_in`  in  1: single-cycle request for a moving-pixel override window.
- `frame_done_in`  in  1: single-cycle pulse from the LED driver, issued once a frame has been fully shifted out.
- `led_out_mux_mode`  out  1: mux mode select. 0 = ID_SHOWER_OUT, 1 = CAMERA_COLOR_OUT.
- `moving_override_out`  out  1: drives the mux moving-pixel override.
- `id_frame_idx_out`  out  $clog2(NUM_ID_FRAMES): index of the ID pattern the ID shower displays.
- `capture_strobe_out`  out  1: one-cycle camera capture strobe.
- `calib_busy_out`  out  1: high while a calibration is pending or running.
- `calib_done_out`  out  1: one-cycle pulse when a calibration completes normally.

## Operation
- All outputs are registered.
- Reset values:
  - state is CAMERA
  - `led_out_mux_mode`=1
  - `moving_override_out`=0
  - `id_frame_idx_out`=0
  - `capture_strobe_out`=0
  - `calib_busy_out`=0
  - `calib_done_out`=0
  - pending flags, `hold_cnt` and `mov_cnt` are all 0
- Term `cp` = `calib_pending | calib_start_in`. A request arriving in the same cycle as `frame_done_in` counts for that boundary.
- State CAMERA (mode=1, override=0):
  - `calib_start_in` sets `calib_pending`; `moving_req_in` sets `moving_pending`.
  - On `frame_done_in` with `cp`: go to CALIB with idx=0, `hold_cnt`=0, mode=0. Clear both pending flags; a pending moving request is dropped.
  - On `frame_done_in` with a moving request pending (flag or same-cycle input) and no `cp`: go to MOVING with `mov_cnt`=0, override=1, and clear the flag.
- State CALIB (mode=0, override=0, busy=1):
  - `moving_req_in` and `calib_start_in` are ignored and not latched.
  - On each `frame_done_in`:
    - If `hold_cnt`==`SETTLE_FRAMES`-1, pulse `capture_strobe_out`.
    - If `hold_cnt`==`FRAMES_PER_ID`-1, set `hold_cnt`=0. If idx==`NUM_ID_FRAMES`-1, go to CAMERA (mode=1, idx=0) and pulse `calib_done_out`; otherwise idx++.
    - Otherwise `hold_cnt`++.
  - `calib_abort_in` sets `abort_pending`. At the next `frame_done_in`: go to CAMERA, idx=0, no strobe, no done pulse, clear `abort_pending`. Abort takes priority over a strobe or done that would fall on the same boundary.
  - `calib_abort_in` outside CALIB is ignored.
- State MOVING (mode=1, override=1):
  - `moving_req_in` retriggers the window: `mov_cnt` is set to 0 in that cycle.
  - `calib_start_in` sets `calib_pending`, and busy goes to 1.
  - On `frame_done_in` with `cp`: go to CALIB. Override falls and mode becomes 0 in the same cycle.
  - Otherwise, on `frame_done_in`: if `mov_cnt`==`MOVING_FRAMES`-1 go to CAMERA (override=0), else `mov_cnt`++.
  - If a retrigger and `frame_done_in` arrive together, the retrigger wins: `mov_cnt`=0 and the block stays in MOVING.
- `calib_busy_out` = (state==CALIB) | `calib_pending`.
- Counter widths:
  - `hold_cnt` is $clog2(`FRAMES_PER_ID`+1) bits.
  - `mov_cnt` is $clog2(`MOVING_FRAMES`+1) bits.
  - Counters never wrap; they are compared and cleared.
- Reset asserted mid-operation returns the block to the reset values on the next edge. Strobes and pulses in flight are lost.

## Timing
- A decision taken on the edge that samples `frame_done_in`=1 is visible on outputs in the following cycle, i.e. one cycle of latency.
- `capture_strobe_out` and `calib_done_out` are exactly one cycle wide and are aligned with that same cycle.
- A request raised with no `frame_done_in` waits for the next boundary. Worst-case latency is one frame plus one cycle.
- One calibration run spans `NUM_ID_FRAMES`×`FRAMES_PER_ID` frame boundaries from entry to exit, and produces exactly `NUM_ID_FRAMES` capture strobes.
- Back-to-back `frame_done_in` on consecutive cycles must be handled; each pulse counts once.

## Test plan
- Reset, then `calib_start_in`, then 64 `frame_done_in` pulses with default parameters:
  - mode goes to 0 one cycle after the first pulse.
  - idx steps 0..15, each index held across 4 frames.
  - 16 capture strobes, each falling on the 2nd boundary of its ID.
  - `calib_done_out` pulses once, then mode=1 and idx=0.
- `moving_req_in`, then 60 frames: override=1 from the cycle after the first boundary and 0 after the 60th. Retrigger at frame 30: override stays 1 for 60 further frames.
- `calib_start_in` during MOVING: at the next boundary override=0 and mode=0 in the same cycle, and calibration runs normally.
- `calib_abort_in` at idx=5, mid-hold: at the next boundary mode=1 and idx=0, with no strobe and no done pulse.
- `calib_start_in` and `moving_req_in` in the same cycle as `frame_done_in` in CAMERA: the block enters CALIB immediately and the moving request is dropped.
- `rst_in` during CALIB with idx=7: the next cycle shows all reset values, and the next `frame_done_in` causes no transition.
